// File: rtl/pid_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pid_seq
//  Purpose  : Multi-cycle PID controller for the balance loop. A pitch and
//             pitch-rate sample is captured on vld. P, I and D are formed
//             over a fixed SAT -> MUL -> INTEG -> SUM sequence, and a
//             saturated control word is issued with a one-cycle PID_vld
//             strobe. The block also provides the soft-start ramp ss_tmr.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             vld               - new sample strobe (ignored while busy)
//             ptch, ptch_rt     - signed pitch / pitch rate, IN_W bits
//             kp                - unsigned proportional gain, KP_W bits
//             rider_off         - clears the integrator on the next edge
//             pwr_up            - enables the soft-start ramp
//             PID_cntrl         - saturated signed control word, OUT_W bits
//             PID_vld           - one-cycle pulse when PID_cntrl updates
//             busy              - high while a sample is in flight
//             ss_tmr            - soft-start level, 0..255
//  Config   : PID_SS_TMR_EN - when defined, the soft-start counter is built.
//             When undefined, ss_tmr is tied to 8'hFF and pwr_up is unused.
//  Revision : 1.0 - initial release
// ============================================================================
module pid_seq #(
    parameter int IN_W     = 16,
    parameter int ERR_W    = 10,
    parameter int INT_W    = 18,
    parameter int I_SHIFT  = 6,
    parameter int D_SHIFT  = 6,
    parameter int KP_W     = 5,
    parameter int OUT_W    = 12,
    parameter int FAST_SIM = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic signed [IN_W-1:0]  ptch,
    input  logic signed [IN_W-1:0]  ptch_rt,
    input  logic        [KP_W-1:0]  kp,
    input  logic                    rider_off,
    input  logic                    pwr_up,
    output logic signed [OUT_W-1:0] PID_cntrl,
    output logic                    PID_vld,
    output logic                    busy,
    output logic        [7:0]       ss_tmr
);

    localparam int c_P_W   = ERR_W + KP_W + 1;
    localparam int c_SUM_W = OUT_W + 4;

    // Clamp limits for the pitch error, expressed at input width
    localparam logic signed [IN_W-1:0] c_err_max =
        {{(IN_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] c_err_min =
        {{(IN_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

    // Clamp limits for the output, expressed at the summing width
    localparam logic signed [c_SUM_W-1:0] c_out_max =
        {{(c_SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_SUM_W-1:0] c_out_min =
        {{(c_SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SAT   = 3'd1,
        S_MUL   = 3'd2,
        S_INTEG = 3'd3,
        S_SUM   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [IN_W-1:0]    r_ptch;
    logic signed [IN_W-1:0]    r_ptch_rt;
    logic        [KP_W-1:0]    r_kp;
    logic signed [ERR_W-1:0]   r_err;
    logic signed [c_P_W-1:0]   r_p;
    logic signed [IN_W:0]      r_d;
    logic signed [INT_W-1:0]   r_i;
    logic signed [INT_W-1:0]   r_integ;

    logic signed [ERR_W-1:0]   w_err;
    logic signed [c_P_W-1:0]   w_p;
    logic signed [IN_W:0]      w_rt_ext;
    logic signed [IN_W:0]      w_d;
    logic signed [INT_W-1:0]   w_err_ext;
    logic signed [INT_W-1:0]   w_sum;
    logic                      w_ovf;
    logic signed [INT_W-1:0]   w_integ_new;
    logic signed [c_SUM_W-1:0] w_total;
    logic signed [OUT_W-1:0]   w_sat;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (vld) w_next_state = S_SAT;
            S_SAT:   w_next_state = S_MUL;
            S_MUL:   w_next_state = S_INTEG;
            S_INTEG: w_next_state = S_SUM;
            S_SUM:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Datapath combinational terms
    // ------------------------------------------------------------------
    always_comb begin
        w_err = r_ptch[ERR_W-1:0];
        if (r_ptch > c_err_max) begin
            w_err = {1'b0, {(ERR_W-1){1'b1}}};
        end else if (r_ptch < c_err_min) begin
            w_err = {1'b1, {(ERR_W-1){1'b0}}};
        end
    end

    // Gain is zero-extended by one bit so the product stays signed
    assign w_p = $signed(c_P_W'(r_err)) * $signed(c_P_W'($signed({1'b0, r_kp})));

    // One extra bit so negating the most negative rate cannot wrap
    assign w_rt_ext = (IN_W+1)'(r_ptch_rt);
    assign w_d      = -(w_rt_ext >>> D_SHIFT);

    assign w_err_ext = INT_W'(r_err);
    assign w_sum     = r_integ + w_err_ext;
    assign w_ovf     = (r_integ[INT_W-1] == w_err_ext[INT_W-1]) &&
                       (w_sum[INT_W-1] != r_integ[INT_W-1]);

    // rider_off wins over the accumulate step in any state
    always_comb begin
        w_integ_new = r_integ;
        if (rider_off) begin
            w_integ_new = '0;
        end else if ((r_state == S_INTEG) && !w_ovf) begin
            w_integ_new = w_sum;
        end
    end

    assign w_total = c_SUM_W'(r_p) + c_SUM_W'(r_i) + c_SUM_W'(r_d);

    always_comb begin
        w_sat = w_total[OUT_W-1:0];
        if (w_total > c_out_max) begin
            w_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_total < c_out_min) begin
            w_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch    <= '0;
            r_ptch_rt <= '0;
            r_kp      <= '0;
            r_err     <= '0;
            r_p       <= '0;
            r_d       <= '0;
            r_i       <= '0;
            r_integ   <= '0;
            PID_cntrl <= '0;
            PID_vld   <= 1'b0;
        end else begin
            PID_vld <= 1'b0;
            r_integ <= w_integ_new;
            case (r_state)
                S_IDLE: begin
                    if (vld) begin
                        r_ptch    <= ptch;
                        r_ptch_rt <= ptch_rt;
                        r_kp      <= kp;
                    end
                end
                S_SAT: begin
                    r_err <= w_err;
                end
                S_MUL: begin
                    r_p <= w_p;
                    r_d <= w_d;
                end
                S_INTEG: begin
                    r_i <= w_integ_new >>> I_SHIFT;
                end
                S_SUM: begin
                    PID_cntrl <= w_sat;
                    PID_vld   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Soft-start ramp
    // ------------------------------------------------------------------
`ifdef PID_SS_TMR_EN
    localparam logic [26:0] c_ss_inc = (FAST_SIM != 0) ? 27'd256 : 27'd1;

    logic [26:0] r_long_tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_tmr <= '0;
        end else if (!pwr_up) begin
            r_long_tmr <= '0;
        end else if (r_long_tmr[26:19] != 8'hFF) begin
            r_long_tmr <= r_long_tmr + c_ss_inc;
        end
    end

    assign ss_tmr = r_long_tmr[26:19];
`else
    logic w_unused_ss;
    assign w_unused_ss = pwr_up | (FAST_SIM != 0);
    assign ss_tmr      = 8'hFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pid_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_seq
//  Purpose  : Self-checking bench for pid_seq. Each accepted sample pushes
//             the value predicted by a behavioural model onto a queue; the
//             entry is popped and compared when PID_vld fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic        [4:0]  kp;
    logic               rider_off;
    logic               pwr_up;
    logic signed [11:0] PID_cntrl;
    logic               PID_vld;
    logic               busy;
    logic        [7:0]  ss_tmr;

    always #5 clk = ~clk;

    pid_seq #(.FAST_SIM(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .kp        (kp),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .PID_cntrl (PID_cntrl),
        .PID_vld   (PID_vld),
        .busy      (busy),
        .ss_tmr    (ss_tmr)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int exp_q[$];
    int m_integ  = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model of one sample; updates the model integrator
    function automatic int model(input int p, input int rt, input int k,
                                 input bit roff);
        int err, pp, d, i, s, t;
        err = (p > 511) ? 511 : ((p < -512) ? -512 : p);
        pp  = err * k;
        d   = -(rt >>> 6);
        if (roff) begin
            m_integ = 0;
            i = 0;
        end else begin
            s = m_integ + err;
            if (s <= 131071 && s >= -131072) m_integ = s;
            i = m_integ >>> 6;
        end
        t = pp + i + d;
        if (t > 2047)  t = 2047;
        if (t < -2048) t = -2048;
        return t;
    endfunction

    // Drive a sample that will be accepted on the next rising edge
    task automatic drive_accept(input int p, input int rt, input int k,
                                input bit roff);
        ptch    = p[15:0];
        ptch_rt = rt[15:0];
        kp      = k[4:0];
        vld     = 1'b1;
        exp_q.push_back(model(p, rt, k, roff));
        @(posedge clk);
        #1;
        vld = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    // Wait for the result; latency counted from the accepting edge
    task automatic wait_result(input string tag);
        int  lat;
        int  expv;
        bit  got;
        got = 1'b0;
        lat = 1;
        for (int e = 2; e <= 9; e++) begin
            @(posedge clk);
            #1;
            lat = e;
            if (PID_vld === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        expv = exp_q.pop_front();
        chk({tag, "_latency"}, got ? lat : -1, 5);
        if (got) begin
            chk({tag, "_value"}, PID_cntrl, expv);
            chk({tag, "_busy_low"}, busy, 0);
        end
    endtask

    task automatic send(input string tag, input int p, input int rt,
                        input int k, input bit roff);
        @(negedge clk);
        rider_off = roff;
        drive_accept(p, rt, k, roff);
        wait_result(tag);
        @(posedge clk);
        #1;
        rider_off = 1'b0;
        chk({tag, "_vld_one_cycle"}, PID_vld, 0);
    endtask

    task automatic clear_integ();
        @(negedge clk);
        rider_off = 1'b1;
        @(negedge clk);
        rider_off = 1'b0;
        m_integ = 0;
    endtask

    initial begin
        int pulses;
        int pulse_at;
        int expv;

        rst_n     = 1'b0;
        vld       = 1'b0;
        ptch      = '0;
        ptch_rt   = '0;
        kp        = '0;
        rider_off = 1'b0;
        pwr_up    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cntrl", PID_cntrl, 0);
        chk("reset_vld",   PID_vld, 0);
        chk("reset_busy",  busy, 0);
`ifdef PID_SS_TMR_EN
        chk("reset_ss_tmr", ss_tmr, 0);
`else
        chk("reset_ss_tmr", ss_tmr, 8'hFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Proportional + integral
        send("p_i", 100, 0, 9, 1'b0);
        chk("p_i_literal", PID_cntrl, 901);

        // Positive and negative saturation
        send("sat_pos", 32767, 0, 9, 1'b0);
        chk("sat_pos_literal", PID_cntrl, 2047);
        clear_integ();
        send("sat_neg", -1000, 0, 9, 1'b0);
        chk("sat_neg_literal", PID_cntrl, -2048);

        // Derivative
        clear_integ();
        send("d_pos_rate", 0, 6400, 0, 1'b0);
        chk("d_pos_literal", PID_cntrl, -100);
        send("d_neg_rate", 0, -640, 0, 1'b0);
        chk("d_neg_literal", PID_cntrl, 10);

        // Output holds between updates
        repeat (5) @(posedge clk);
        #1;
        chk("hold_between", PID_cntrl, 10);

        // Anti-windup
        clear_integ();
        for (int n = 0; n < 256; n++) begin
            send("windup", 511, 0, 0, 1'b0);
        end
        chk("integ_256", dut.r_integ, 130816);
        send("windup_ovf", 511, 0, 0, 1'b0);
        chk("integ_hold", dut.r_integ, 130816);
        chk("windup_ovf_literal", PID_cntrl, 2044);
        clear_integ();
        @(posedge clk);
        #1;
        chk("integ_cleared", dut.r_integ, 0);

        // rider_off held through a sample: I contribution is zero
        send("rider_off_flight", 100, 0, 9, 1'b1);
        chk("rider_off_literal", PID_cntrl, 900);

        // Busy drop: second vld two edges later is ignored
        @(negedge clk);
        ptch = 16'sd200; ptch_rt = '0; kp = 5'd1; vld = 1'b1;
        exp_q.push_back(model(200, 0, 1, 1'b0));
        @(posedge clk);
        #1;
        vld = 1'b0;
        pulses   = 0;
        pulse_at = -1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e == 2) begin
                ptch = 16'sd300;
                vld  = 1'b1;
            end else begin
                vld  = 1'b0;
            end
            @(posedge clk);
            #1;
            if (PID_vld === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = e;
            end
        end
        expv = exp_q.pop_front();
        chk("busy_drop_pulses", pulses, 1);
        chk("busy_drop_edge", pulse_at, 4);
        chk("busy_drop_value", PID_cntrl, expv);

        // vld in the PID_vld cycle is accepted back to back
        @(negedge clk);
        drive_accept(50, 0, 2, 1'b0);
        wait_result("b2b_first");
        drive_accept(-60, 128, 3, 1'b0);
        wait_result("b2b_second");

        // Reset mid-sequence aborts without a pulse
        @(negedge clk);
        drive_accept(100, 0, 9, 1'b0);
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cntrl", PID_cntrl, 0);
        m_integ = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (PID_vld === 1'b1) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        send("after_abort", 100, 0, 9, 1'b0);

        // Soft start
        @(negedge clk);
        pwr_up = 1'b1;
        repeat (4096) @(posedge clk);
        #1;
`ifdef PID_SS_TMR_EN
        chk("ss_ramp", ss_tmr, 2);
`else
        chk("ss_tied", ss_tmr, 8'hFF);
`endif
        @(negedge clk);
        pwr_up = 1'b0;
        @(posedge clk);
        #1;
`ifdef PID_SS_TMR_EN
        chk("ss_clear", ss_tmr, 0);
`else
        chk("ss_tied_off", ss_tmr, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
